frame_buf_arbiter: RTL and testbench

Frame-buffer scheduler that generalises ping-pong SDRAM buffering to NUM_BUF frame buffers with independent writer and reader channels. On each frame toggle it issues one-cycle load commands, with base address and length, to the SDRAM memory controller (sdram_mcb). The reader always gets the newest completed frame; the writer gets a free buffer. Overlap, repeat and drop events are counted. It sits between the video source/sink frame logic and sdram_mcb, all on the SDRAM clock.

---
 rtl/fb_arb_pkg.sv | 33 +++
 rtl/buf_chan_fsm.sv | 61 ++++++
 rtl/frame_buf_arbiter.sv | 124 ++++++++++++
 tb/tb_frame_buf_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the frame-buffer arbiter: channel states,
// buffer index width and the buffer-index to base-address mux.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2
    } chan_state_t;

    // Up to four buffers, so a buffer index always fits in two bits
    localparam int IDX_W = 2;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input int unsigned      num_buf);
        return (32'(idx) == num_buf - 1) ? '0 : idx + 1'b1;
    endfunction

    // Each arm folds to a constant, so this is a 4:1 mux with no multiplier
    function automatic logic [31:0] buf_addr(input logic [IDX_W-1:0] idx,
                                             input int unsigned      base,
                                             input int unsigned      stride);
        logic [31:0] addr;
        case (idx)
            2'd0:    addr = base;
            2'd1:    addr = base + stride;
            2'd2:    addr = base + 2 * stride;
            default: addr = base + 3 * stride;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/buf_chan_fsm.sv
// One frame channel: IDLE -> LOAD (one-cycle load pulse) -> BUSY until its
// done pulse, plus a saturating count of kickoffs that find it occupied.
module buf_chan_fsm
    import fb_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kick,
    input  logic             go,
    input  logic             done,
    output logic             load,
    output logic             busy,
    output logic             free,
    output logic [CNT_W-1:0] overlap_cnt
);

    chan_state_t      state_reg;
    chan_state_t      state_next;
    logic [CNT_W-1:0] cnt_reg;

    // A done arriving together with a kickoff frees the channel for it
    assign free        = (state_reg == IDLE) || ((state_reg == BUSY) && done);
    assign load        = (state_reg == LOAD);
    assign busy        = (state_reg == BUSY);
    assign overlap_cnt = cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (go) state_next = LOAD;
            LOAD: state_next = BUSY;
            BUSY: begin
                if (go) begin
                    state_next = LOAD;
                end else if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (kick && !free && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// NUM_BUF-way frame-buffer scheduler: the reader takes the newest completed
// frame, the writer takes a buffer the reader is not using.
module frame_buf_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned NUM_BUF     = 3,
    parameter int unsigned FRAME_DEPTH = 1024 * 768,
    parameter int unsigned BUF_STRIDE  = 1024 * 1024,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          ADDR_W      = 24,
    parameter int          CNT_W       = 8
) (
    input  logic              clk_sdram,
    input  logic              rst_n,
    input  logic              mem_rdy,
    input  logic              mem_toggle,
    output logic              wr_load,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wr_length,
    input  logic              wr_done,
    output logic              rd_load,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_length,
    input  logic              rd_done,
    output logic              wr_active,
    output logic              rd_active,
    output logic [1:0]        wr_buf,
    output logic [1:0]        rd_buf,
    output logic [CNT_W-1:0]  wr_overlap_cnt,
    output logic [CNT_W-1:0]  rd_overlap_cnt,
    output logic [CNT_W-1:0]  wr_skip_cnt
);

    logic [2:0]        sync_reg;
    logic              kick;
    logic [IDX_W-1:0]  last_done_reg, last_done_eff;
    logic [IDX_W-1:0]  wr_buf_reg, rd_buf_reg, rd_buf_next;
    logic [IDX_W-1:0]  wr_cand1, wr_cand;
    logic [ADDR_W-1:0] wr_addr_reg, rd_addr_reg;
    logic [CNT_W-1:0]  skip_cnt_reg;
    logic              wr_free, rd_free, wr_busy, rd_busy;
    logic              wr_go, rd_go, wr_collide;

    always_ff @(posedge clk_sdram) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], mem_toggle};
        end
    end

    assign kick = sync_reg[1] && !sync_reg[2] && mem_rdy;

    // Done is applied before the kickoff decision in the same cycle
    always_comb begin
        last_done_eff = (wr_busy && wr_done) ? wr_buf_reg : last_done_reg;
        rd_go         = kick && rd_free;
        rd_buf_next   = rd_go ? last_done_eff : rd_buf_reg;
        wr_cand1      = next_idx(last_done_eff, NUM_BUF);
        wr_cand       = (wr_cand1 == rd_buf_next) ? next_idx(wr_cand1, NUM_BUF) : wr_cand1;
        // With two buffers the fallback wraps onto the newest frame: skip instead
        wr_collide    = (wr_cand == rd_buf_next) || (wr_cand == last_done_eff);
        wr_go         = kick && wr_free && !wr_collide;
    end

    always_ff @(posedge clk_sdram) begin
        if (!rst_n) begin
            last_done_reg <= '0;
            wr_buf_reg    <= '0;
            rd_buf_reg    <= '0;
            wr_addr_reg   <= '0;
            rd_addr_reg   <= '0;
            skip_cnt_reg  <= '0;
        end else begin
            last_done_reg <= last_done_eff;
            rd_buf_reg    <= rd_buf_next;
            if (rd_go) begin
                rd_addr_reg <= ADDR_W'(buf_addr(rd_buf_next, BASE_ADDR, BUF_STRIDE));
            end
            if (wr_go) begin
                wr_buf_reg  <= wr_cand;
                wr_addr_reg <= ADDR_W'(buf_addr(wr_cand, BASE_ADDR, BUF_STRIDE));
            end
            if (kick && wr_free && wr_collide && (skip_cnt_reg != '1)) begin
                skip_cnt_reg <= skip_cnt_reg + 1'b1;
            end
        end
    end

    buf_chan_fsm #(.CNT_W(CNT_W)) u_wr_chan (
        .clk         (clk_sdram),
        .rst_n       (rst_n),
        .kick        (kick),
        .go          (wr_go),
        .done        (wr_done),
        .load        (wr_load),
        .busy        (wr_busy),
        .free        (wr_free),
        .overlap_cnt (wr_overlap_cnt)
    );

    buf_chan_fsm #(.CNT_W(CNT_W)) u_rd_chan (
        .clk         (clk_sdram),
        .rst_n       (rst_n),
        .kick        (kick),
        .go          (rd_go),
        .done        (rd_done),
        .load        (rd_load),
        .busy        (rd_busy),
        .free        (rd_free),
        .overlap_cnt (rd_overlap_cnt)
    );

    assign wr_active   = wr_busy;
    assign rd_active   = rd_busy;
    assign wr_buf      = wr_buf_reg;
    assign rd_buf      = rd_buf_reg;
    assign wr_addr     = wr_addr_reg;
    assign rd_addr     = rd_addr_reg;
    assign wr_skip_cnt = skip_cnt_reg;
    assign wr_length   = ADDR_W'(FRAME_DEPTH - 1);
    assign rd_length   = ADDR_W'(FRAME_DEPTH - 1);

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Drives two arbiters (three buffers with 2-bit counters, two buffers with an
// offset base) frame by frame and compares them with a frame-level model.
module tb_frame_buf_arbiter;

    logic clk_sdram = 1'b0;
    always #5 clk_sdram = ~clk_sdram;

    logic rst_n, mem_rdy, mem_toggle;
    logic [1:0] wr_done, rd_done, wr_load, rd_load, wr_active, rd_active;
    logic [1:0][23:0] wr_addr, rd_addr, wr_length, rd_length;
    logic [1:0][1:0]  wr_buf, rd_buf;
    logic [1:0] wov0, rov0, skip0;
    logic [7:0] wov1, rov1, skip1;
    logic [1:0][31:0] o_wov, o_rov, o_skip;

    assign o_wov[0]  = 32'(wov0);
    assign o_rov[0]  = 32'(rov0);
    assign o_skip[0] = 32'(skip0);
    assign o_wov[1]  = 32'(wov1);
    assign o_rov[1]  = 32'(rov1);
    assign o_skip[1] = 32'(skip1);

    frame_buf_arbiter #(
        .NUM_BUF(3), .FRAME_DEPTH(1024 * 768), .BUF_STRIDE(1024 * 1024),
        .BASE_ADDR(0), .ADDR_W(24), .CNT_W(2)
    ) dut3 (
        .clk_sdram(clk_sdram), .rst_n(rst_n), .mem_rdy(mem_rdy), .mem_toggle(mem_toggle),
        .wr_load(wr_load[0]), .wr_addr(wr_addr[0]), .wr_length(wr_length[0]), .wr_done(wr_done[0]),
        .rd_load(rd_load[0]), .rd_addr(rd_addr[0]), .rd_length(rd_length[0]), .rd_done(rd_done[0]),
        .wr_active(wr_active[0]), .rd_active(rd_active[0]), .wr_buf(wr_buf[0]), .rd_buf(rd_buf[0]),
        .wr_overlap_cnt(wov0), .rd_overlap_cnt(rov0), .wr_skip_cnt(skip0)
    );

    frame_buf_arbiter #(
        .NUM_BUF(2), .FRAME_DEPTH(640 * 480), .BUF_STRIDE('h8_0000),
        .BASE_ADDR('h40_0000), .ADDR_W(24), .CNT_W(8)
    ) dut2 (
        .clk_sdram(clk_sdram), .rst_n(rst_n), .mem_rdy(mem_rdy), .mem_toggle(mem_toggle),
        .wr_load(wr_load[1]), .wr_addr(wr_addr[1]), .wr_length(wr_length[1]), .wr_done(wr_done[1]),
        .rd_load(rd_load[1]), .rd_addr(rd_addr[1]), .rd_length(rd_length[1]), .rd_done(rd_done[1]),
        .wr_active(wr_active[1]), .rd_active(rd_active[1]), .wr_buf(wr_buf[1]), .rd_buf(rd_buf[1]),
        .wr_overlap_cnt(wov1), .rd_overlap_cnt(rov1), .wr_skip_cnt(skip1)
    );

    // Model parameters per instance
    int unsigned m_n[2]      = '{3, 2};
    int unsigned m_base[2]   = '{0, 'h40_0000};
    int unsigned m_stride[2] = '{1024 * 1024, 'h8_0000};
    int unsigned m_cmax[2]   = '{3, 255};
    int unsigned m_len[2]    = '{1024 * 768 - 1, 640 * 480 - 1};

    // Model state: channel occupancy, buffer ownership, counters
    bit          m_wb[2], m_rb[2], exp_wl[2], exp_rl[2];
    int unsigned m_last[2], m_wbuf[2], m_rbuf[2], m_waddr[2], m_raddr[2];
    int unsigned m_wov[2], m_rov[2], m_skip[2];

    int errors = 0;
    int checks = 0;
    int frame_no = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wb[d] = 0; m_rb[d] = 0; exp_wl[d] = 0; exp_rl[d] = 0;
            m_last[d] = 0; m_wbuf[d] = 0; m_rbuf[d] = 0; m_waddr[d] = 0; m_raddr[d] = 0;
            m_wov[d] = 0; m_rov[d] = 0; m_skip[d] = 0;
        end
    endtask

    task automatic model_frame(input int d, input bit wd, input bit rdn, input bit kick);
        int unsigned cand;
        exp_wl[d] = 0;
        exp_rl[d] = 0;
        if (wd && m_wb[d]) begin
            m_wb[d]   = 0;
            m_last[d] = m_wbuf[d];
        end
        if (rdn && m_rb[d]) m_rb[d] = 0;
        if (kick) begin
            if (m_rb[d]) begin
                if (m_rov[d] < m_cmax[d]) m_rov[d]++;
            end else begin
                m_rbuf[d]  = m_last[d];
                m_raddr[d] = m_base[d] + m_rbuf[d] * m_stride[d];
                m_rb[d]    = 1;
                exp_rl[d]  = 1;
            end
            if (m_wb[d]) begin
                if (m_wov[d] < m_cmax[d]) m_wov[d]++;
            end else begin
                cand = (m_last[d] + 1) % m_n[d];
                if (cand == m_rbuf[d]) cand = (cand + 1) % m_n[d];
                if (cand == m_rbuf[d] || cand == m_last[d]) begin
                    if (m_skip[d] < m_cmax[d]) m_skip[d]++;
                end else begin
                    m_wbuf[d]  = cand;
                    m_waddr[d] = m_base[d] + cand * m_stride[d];
                    m_wb[d]    = 1;
                    exp_wl[d]  = 1;
                end
            end
        end
    endtask

    task automatic check_quiet();
        for (int d = 0; d < 2; d++) begin
            chk("early_wr_load", d, 32'(wr_load[d]), 32'd0);
            chk("early_rd_load", d, 32'(rd_load[d]), 32'd0);
        end
    endtask

    task automatic check_load();
        for (int d = 0; d < 2; d++) begin
            chk("wr_load", d, 32'(wr_load[d]), 32'(exp_wl[d]));
            chk("rd_load", d, 32'(rd_load[d]), 32'(exp_rl[d]));
            chk("wr_buf", d, 32'(wr_buf[d]), m_wbuf[d]);
            chk("rd_buf", d, 32'(rd_buf[d]), m_rbuf[d]);
            chk("wr_addr", d, 32'(wr_addr[d]), m_waddr[d]);
            chk("rd_addr", d, 32'(rd_addr[d]), m_raddr[d]);
            chk("wr_length", d, 32'(wr_length[d]), m_len[d]);
            chk("rd_length", d, 32'(rd_length[d]), m_len[d]);
            chk("wr_overlap_cnt", d, o_wov[d], m_wov[d]);
            chk("rd_overlap_cnt", d, o_rov[d], m_rov[d]);
            chk("wr_skip_cnt", d, o_skip[d], m_skip[d]);
        end
    endtask

    task automatic check_active();
        for (int d = 0; d < 2; d++) begin
            chk("late_wr_load", d, 32'(wr_load[d]), 32'd0);
            chk("late_rd_load", d, 32'(rd_load[d]), 32'd0);
            chk("wr_active", d, 32'(wr_active[d]), 32'(m_wb[d]));
            chk("rd_active", d, 32'(rd_active[d]), 32'(m_rb[d]));
        end
    endtask

    // One frame: toggle rises, done pulses land before or with the kickoff
    task automatic frame(input bit [1:0] wd, input bit [1:0] rdn, input bit same);
        frame_no++;
        mem_toggle = 1'b1;
        if (!same) begin
            wr_done = wd;
            rd_done = rdn;
        end
        @(negedge clk_sdram);
        wr_done = '0;
        rd_done = '0;
        @(negedge clk_sdram);
        check_quiet();
        if (same) begin
            wr_done = wd;
            rd_done = rdn;
        end
        for (int d = 0; d < 2; d++) model_frame(d, wd[d], rdn[d], mem_rdy);
        @(negedge clk_sdram);
        wr_done = '0;
        rd_done = '0;
        check_load();
        @(negedge clk_sdram);
        check_active();
        mem_toggle = 1'b0;
        $display("frame %0d rdy=%0b wd=%b rd=%b same=%0b | dut3 wr_buf=%0d rd_buf=%0d | dut2 wr_buf=%0d rd_buf=%0d",
                 frame_no, mem_rdy, wd, rdn, same, wr_buf[0], rd_buf[0], wr_buf[1], rd_buf[1]);
        repeat (3) @(negedge clk_sdram);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk_sdram);
        model_reset();
        check_load();
        check_active();
        $display("reset applied");
        rst_n = 1'b1;
        @(negedge clk_sdram);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_rdy    = 1'b0;
        mem_toggle = 1'b0;
        wr_done    = '0;
        rd_done    = '0;
        repeat (2) @(negedge clk_sdram);
        model_reset();
        check_load();
        check_active();
        rst_n   = 1'b1;
        mem_rdy = 1'b1;
        @(negedge clk_sdram);

        // Steady rotation with every frame completed
        repeat (4) frame(2'b11, 2'b11, 1'b0);
        // dut3 writer stalls (overlap saturates at 3), dut2 reader stalls (skips)
        repeat (5) frame(2'b10, 2'b01, 1'b0);
        // Done in the same cycle as the kickoff
        repeat (2) frame(2'b11, 2'b11, 1'b1);
        // Controller not ready: kickoffs ignored
        mem_rdy = 1'b0;
        repeat (3) frame(2'b11, 2'b11, 1'b0);
        mem_rdy = 1'b1;

        for (int i = 0; i < 40; i++) begin
            mem_rdy = ($urandom_range(0, 7) != 0);
            frame(2'($urandom), 2'($urandom), 1'($urandom));
        end
        mem_rdy = 1'b1;

        // Reset while both channels are busy, then restart from buffer 1 / 0
        frame(2'b11, 2'b11, 1'b0);
        do_reset();
        frame(2'b00, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
